// File: rtl/counter_mod_n_pkg.sv
// Shared definitions for the modulo-N counter and its seven-segment decoder.
// Holds the nibble-to-segment table and the digit-count helper.
// Segment polarity: active-high, bit order {g,f,e,d,c,b,a}.
package counter_mod_n_pkg;

   // Segment codes for hex digits 0..F, active-high, {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,  // 0 1 2 3
      7'h66, 7'h6D, 7'h7D, 7'h07,  // 4 5 6 7
      7'h7F, 7'h6F, 7'h77, 7'h7C,  // 8 9 A b
      7'h39, 7'h5E, 7'h79, 7'h71   // C d E F
   };

   // Number of 4-bit display digits needed to show a WIDTH-bit count.
   function automatic int digits_for(input int width);
      return (width + 3) / 4;
   endfunction

endpackage

// File: rtl/counter_mod_n_if.sv
// Control/status bundle between a counter_mod_n stage and its user.
// Ports: iEn/iUp/iLoad/iLoadVal toward the counter; oQ/oTC/oWrap/oDisplay back.
// slave = counter side, master = switch/button/display side.
interface counter_mod_n_if #(
   parameter int WIDTH = 4
) ();

   localparam int DIGITS = counter_mod_n_pkg::digits_for(WIDTH);

   logic                  iEn;
   logic                  iUp;
   logic                  iLoad;
   logic [WIDTH-1:0]      iLoadVal;
   logic [WIDTH-1:0]      oQ;
   logic                  oTC;
   logic                  oWrap;
   logic [7*DIGITS-1:0]   oDisplay;

   modport slave (
      input  iEn, iUp, iLoad, iLoadVal,
      output oQ, oTC, oWrap, oDisplay
   );

   modport master (
      output iEn, iUp, iLoad, iLoadVal,
      input  oQ, oTC, oWrap, oDisplay
   );

endinterface

// File: rtl/counter_mod_n_display7.sv
// display7: hex nibble to seven-segment decoder, purely combinational.
// Ports: nibble (4-bit value in), seg (7-bit segment code out).
// Polarity and bit order follow SEG_TABLE in the package.
module display7
   import counter_mod_n_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/counter_mod_n.sv
// counter_mod_n: parametrised synchronous modulo-MOD up/down counter with load.
// Ports: CLK, rst (async, active-high); bus (slave) carries enable/direction/load
// in and count, terminal count, wrap pulse and seven-segment digits out.
// Optional: define COUNTER_MOD_N_SAT_EN to saturate at the limits instead of wrapping.
module counter_mod_n
   import counter_mod_n_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MOD   = 16
) (
   input  logic           CLK,
   input  logic           rst,
   counter_mod_n_if.slave bus
);

   localparam int DIGITS = digits_for(WIDTH);

   // Largest legal count, held in WIDTH bits so MOD = 2**WIDTH never overflows.
   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

`ifdef COUNTER_MOD_N_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("counter_mod_n: WIDTH must be in 1..16");
   end
   if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
      $error("counter_mod_n: MOD must be in 2..2**WIDTH");
   end

   logic [WIDTH-1:0] q;
   logic             wrap;
   logic             at_top;
   logic             at_bottom;

   assign at_top    = (q == MAX_Q);
   assign at_bottom = (q == '0);

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         q    <= '0;
         wrap <= 1'b0;
      end else if (bus.iLoad) begin
         // Out-of-range load values clamp to the top of the sequence.
         q    <= (bus.iLoadVal > MAX_Q) ? MAX_Q : bus.iLoadVal;
         wrap <= 1'b0;
      end else if (bus.iEn) begin
         if (bus.iUp) begin
            if (at_top) begin
               q    <= SAT_EN ? MAX_Q : '0;
               wrap <= ~SAT_EN;
            end else begin
               q    <= q + ONE;
               wrap <= 1'b0;
            end
         end else begin
            if (at_bottom) begin
               q    <= SAT_EN ? '0 : MAX_Q;
               wrap <= ~SAT_EN;
            end else begin
               q    <= q - ONE;
               wrap <= 1'b0;
            end
         end
      end else begin
         wrap <= 1'b0;
      end
   end

   assign bus.oQ    = q;
   assign bus.oWrap = wrap;

   // Combinational so the next cascaded stage sees it as iEn on this same edge.
   assign bus.oTC = bus.iEn & ~bus.iLoad &
                    ((bus.iUp & at_top) | (~bus.iUp & at_bottom));

   // Zero-extend the count to whole nibbles for the top digit.
   logic [4*DIGITS-1:0] q_pad;
   logic [7*DIGITS-1:0] disp;

   assign q_pad = (4*DIGITS)'(q);

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      display7 u_display7 (
         .nibble (q_pad[4*k +: 4]),
         .seg    (disp[7*k +: 7])
      );
   end

   assign bus.oDisplay = disp;

endmodule
